// File: rtl/load_store_unit.sv
// Load/store unit between the execute stage and a word-only DataMem port: byte/half/word, little-endian.
// Define MISALIGN_SPLIT_EN to split misaligned accesses into two word accesses; otherwise they fault.
module load_store_unit #(
  parameter int MEM_WORDS = 32
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_req,
  output logic        o_ready,
  input  logic        i_op_write,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic        o_fault,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_memW_val,
  output logic        o_MemWrite,
  input  logic [31:0] i_mem_read
);

`ifdef MISALIGN_SPLIT_EN
  localparam logic SPLIT_EN = 1'b1;
`else
  localparam logic SPLIT_EN = 1'b0;
`endif
  localparam logic [31:0] WORDS = 32'(MEM_WORDS);

  typedef enum logic [2:0] {S_IDLE, S_RD0, S_RD1, S_WR0, S_WR1, S_DONE} state_t;

  state_t      state_q, state_d;
  logic        write_q, write_d, signed_q, signed_d;
  logic        misal_q, misal_d, fault_q, fault_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [31:0] buf0_q, buf0_d, buf1_q, buf1_d;
  logic        ready_q, ready_d, done_q, done_d, fault_out_q, fault_out_d, mem_we_q, mem_we_d;
  logic [31:0] rdata_q, rdata_d, mem_addr_q, mem_addr_d, mem_wval_q, mem_wval_d;

  logic [2:0]  req_bytes;
  logic [31:0] req_idx;
  logic        req_misal, req_fault;

  always_comb begin
    req_idx = {2'b00, i_addr[31:2]};
    case (i_size)
      2'b00:   req_bytes = 3'd1;
      2'b01:   req_bytes = 3'd2;
      default: req_bytes = 3'd4;
    endcase
    req_misal = ({1'b0, i_addr[1:0]} + req_bytes) > 3'd4;
    req_fault = (i_size == 2'b11) || (req_idx >= WORDS) ||
                (req_misal && (!SPLIT_EN || ((req_idx + 32'd1) >= WORDS)));
  end

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    signed_d = signed_q;
    misal_d  = misal_q;
    fault_d  = fault_q;
    size_d   = size_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    buf0_d   = buf0_q;
    buf1_d   = buf1_q;
    case (state_q)
      S_IDLE: if (i_req) begin
        write_d  = i_op_write;
        signed_d = i_signed;
        size_d   = i_size;
        addr_d   = i_addr;
        wdata_d  = i_wdata;
        misal_d  = req_misal;
        fault_d  = req_fault;
        if (req_fault)                                        state_d = S_DONE;
        else if (i_op_write && i_size == 2'b10 && !req_misal) state_d = S_WR0;
        else                                                  state_d = S_RD0;
      end
      S_RD0: begin
        buf0_d = i_mem_read;
        if (SPLIT_EN && misal_q) state_d = S_RD1;
        else if (write_q)        state_d = S_WR0;
        else                     state_d = S_DONE;
      end
`ifdef MISALIGN_SPLIT_EN
      S_RD1: begin
        buf1_d  = i_mem_read;
        state_d = write_q ? S_WR0 : S_DONE;
      end
      S_WR1:   state_d = S_DONE;
`endif
      S_WR0:   state_d = (SPLIT_EN && misal_q) ? S_WR1 : S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered, so they are derived from next-state values.
  logic [63:0] wide, mask64, data64, merged;
  logic [31:0] mask32, sel, ext;
  logic [4:0]  sh;
  logic [29:0] idx_d;

  always_comb begin
    wide  = {buf1_d, buf0_d};
    sh    = {addr_d[1:0], 3'b000};
    idx_d = addr_d[31:2];
    case (size_d)
      2'b00:   mask32 = 32'h0000_00FF;
      2'b01:   mask32 = 32'h0000_FFFF;
      default: mask32 = 32'hFFFF_FFFF;
    endcase
    mask64 = {32'h0, mask32} << sh;
    data64 = {32'h0, wdata_d & mask32} << sh;
    merged = (wide & ~mask64) | data64;
    sel    = wide[sh +: 32];
    case (size_d)
      2'b00:   ext = {{24{signed_d & sel[7]}}, sel[7:0]};
      2'b01:   ext = {{16{signed_d & sel[15]}}, sel[15:0]};
      default: ext = sel;
    endcase

    ready_d     = (state_d == S_IDLE);
    done_d      = (state_d == S_DONE);
    fault_out_d = done_d && fault_d;
    rdata_d     = (done_d && !write_d && !fault_d) ? ext : 32'h0;
    mem_we_d    = (state_d == S_WR0) || (state_d == S_WR1);
    mem_addr_d  = 32'h0;
    mem_wval_d  = 32'h0;
    if (state_d == S_RD0 || state_d == S_WR0) mem_addr_d = {idx_d, 2'b00};
    if (state_d == S_RD1 || state_d == S_WR1) mem_addr_d = {idx_d + 30'd1, 2'b00};
    if (state_d == S_WR0) mem_wval_d = merged[31:0];
    if (state_d == S_WR1) mem_wval_d = merged[63:32];
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      write_q     <= 1'b0;
      signed_q    <= 1'b0;
      misal_q     <= 1'b0;
      fault_q     <= 1'b0;
      size_q      <= 2'b00;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      buf0_q      <= 32'h0;
      buf1_q      <= 32'h0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      fault_out_q <= 1'b0;
      mem_we_q    <= 1'b0;
      rdata_q     <= 32'h0;
      mem_addr_q  <= 32'h0;
      mem_wval_q  <= 32'h0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      signed_q    <= signed_d;
      misal_q     <= misal_d;
      fault_q     <= fault_d;
      size_q      <= size_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      fault_out_q <= fault_out_d;
      mem_we_q    <= mem_we_d;
      rdata_q     <= rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wval_q  <= mem_wval_d;
    end
  end

  assign o_ready    = ready_q;
  assign o_done     = done_q;
  assign o_fault    = fault_out_q;
  assign o_rdata    = rdata_q;
  assign o_MemWrite = mem_we_q;
  assign o_mem_addr = mem_addr_q;
  assign o_memW_val = mem_wval_q;

endmodule
